word_pack_wr: RTL

//  Downstream consumer of the FIFO read side in ctrl_blk_2m. Issues fifo_rd

---
 rtl/ctrl_blk_pkg.sv | 19 +
 rtl/wp_addr_cnt.sv | 37 +++
 rtl/word_pack_wr.sv | 104 ++++++++++
 3 files changed

// File: rtl/ctrl_blk_pkg.sv
// Shared types and constants for the ctrl_blk_2m byte-FIFO to RAM path.
//   wp_state_t     : word packer state (FILL = gathering bytes, HOLD = word on RAM port)
//   BYTES_PER_WORD : bytes assembled into one RAM word
//   BYTE_W         : FIFO data width
//   WORD_W         : RAM data width
//   CNT_W          : width of the per-word byte counters (must hold BYTES_PER_WORD)
package ctrl_blk_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } wp_state_t;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = BYTES_PER_WORD * BYTE_W;
  localparam int unsigned CNT_W          = 3;

endpackage

// File: rtl/wp_addr_cnt.sv
// Wrapping RAM write-address counter for the word packer.
//   clk   : clock, posedge
//   reset : synchronous, active-high; clears addr and wrap
//   inc   : advance the address by one (a word was accepted)
//   addr  : current write address, wraps from RAM_DEPTH-1 to 0
//   wrap  : registered 1-cycle pulse after an increment taken at RAM_DEPTH-1
module wp_addr_cnt #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned RAM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic              wrap
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);

  logic at_last;

  assign at_last = (addr == LAST_ADDR);

  // Address register and wrap pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= inc && at_last;
      if (inc) begin
        addr <= at_last ? '0 : addr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/word_pack_wr.sv
// Word packer: reads bytes from the ctrl_blk_2m byte FIFO, packs four of them
// (first byte in [31:24]) into a 32-bit word and writes it to RAM with a
// valid/ready handshake at an auto-incrementing, wrapping address.
//   clk, reset : clock (posedge) and synchronous active-high reset
//   fifo_empty : FIFO has no data; no read strobe is issued while high
//   fifo_data  : FIFO read data, valid the cycle after fifo_rd
//   fifo_rd    : read strobe, one byte per high cycle (combinational)
//   ram_wr     : word valid, held until ram_ready
//   ram_ready  : RAM accepts the word in a cycle with ram_wr && ram_ready
//   ram_addr   : write address, stable while ram_wr is high
//   ram_data   : packed word, stable while ram_wr is high
//   wrap       : 1-cycle pulse after the word at RAM_DEPTH-1 is accepted
module word_pack_wr
  import ctrl_blk_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned RAM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo_empty,
  input  logic [7:0]        fifo_data,
  output logic              fifo_rd,
  output logic              ram_wr,
  input  logic              ram_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_data,
  output logic              wrap
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BYTES_PER_WORD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES_PER_WORD - 1);
  localparam int unsigned      ASM_W    = WORD_W - BYTE_W;

  wp_state_t          state;
  logic [CNT_W-1:0]   issue_cnt;
  logic [CNT_W-1:0]   cap_cnt;
  logic               rd_vld;
  logic [ASM_W-1:0]   asm_bytes;
  logic [WORD_W-1:0]  next_word;
  logic               accept;

  // Reads stop at four strobes per word; reset masks the strobe so no byte
  // is popped from the FIFO and then dropped.
  assign fifo_rd = !reset && (state == FILL) && !fifo_empty && (issue_cnt < CNT_FULL);

  // Only the three earlier bytes need storage; the fourth comes straight
  // from fifo_data when the word completes.
  assign next_word = {asm_bytes, fifo_data};

  assign accept = (state == HOLD) && ram_wr && ram_ready;

  wp_addr_cnt #(
    .ADDR_W    (ADDR_W),
    .RAM_DEPTH (RAM_DEPTH)
  ) u_addr_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (accept),
    .addr  (ram_addr),
    .wrap  (wrap)
  );

  // Packer FSM with byte capture and RAM-port registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FILL;
      issue_cnt <= '0;
      cap_cnt   <= '0;
      rd_vld    <= 1'b0;
      asm_bytes <= '0;
      ram_wr    <= 1'b0;
      ram_data  <= '0;
    end else begin
      rd_vld <= fifo_rd;
      case (state)
        FILL: begin
          if (fifo_rd) begin
            issue_cnt <= issue_cnt + CNT_W'(1);
          end
          if (rd_vld) begin
            asm_bytes <= next_word[ASM_W-1:0];
            cap_cnt   <= cap_cnt + CNT_W'(1);
            if (cap_cnt == CNT_LAST) begin
              ram_data <= next_word;
              ram_wr   <= 1'b1;
              state    <= HOLD;
            end
          end
        end
        HOLD: begin
          if (ram_ready) begin
            ram_wr    <= 1'b0;
            issue_cnt <= '0;
            cap_cnt   <= '0;
            state     <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule
